// File: rtl/uds_pkg.sv
// Shared definitions for the up/down-sample output packer.
// Beat geometry, tile-size helpers and the per-slot metadata record.
package uds_pkg;

    localparam int ROW_ITEMS = 8;
    localparam int ITEM_W    = 32;
    localparam int BEAT_W    = ROW_ITEMS * ITEM_W;

    // Beat count and tile id widths carried with every buffered tile.
    localparam int BCNT_W = 8;
    localparam int ID_W   = 8;

    // Width of one result tile for A items per tile.
    function automatic int calc_in_w(input int a);
        return 2 * (a - 8) * ITEM_W;
    endfunction

    // Number of 256-bit row beats in a full tile.
    function automatic int calc_num_beats(input int a);
        return calc_in_w(a) / BEAT_W;
    endfunction

    // Metadata stored next to each tile: beats to emit and sequence id.
    typedef struct packed {
        logic [BCNT_W-1:0] beats;
        logic [ID_W-1:0]   id;
    } slot_meta_t;

endpackage

// File: rtl/uds_tile_slot2.sv
// Two-entry ping-pong tile store: write/read pointers and occupancy.
// The caller only asserts wr_en when a slot is free or being freed.
module uds_tile_slot2
    import uds_pkg::*;
#(
    parameter int IN_W = 3584
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [IN_W-1:0] wr_tile,
    input  slot_meta_t      wr_meta,
    input  logic            rd_pop,
    output logic [IN_W-1:0] cur_tile,
    output slot_meta_t      cur_meta,
    output logic [IN_W-1:0] nxt_tile,
    output slot_meta_t      nxt_meta,
    output logic [1:0]      occupancy
);

    typedef struct packed {
        logic [IN_W-1:0] tile;
        slot_meta_t      meta;
    } slot_t;

    slot_t      slot_q [2];
    slot_t      slot_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;

    // Next-state: write at wr_ptr, pop at rd_ptr, occupancy tracks both.
    always_comb begin
        slot_d = slot_q;
        if (wr_en) begin
            slot_d[wr_ptr_q].tile = wr_tile;
            slot_d[wr_ptr_q].meta = wr_meta;
        end
        wr_ptr_d = wr_ptr_q ^ wr_en;
        rd_ptr_d = rd_ptr_q ^ rd_pop;
        occ_d    = occ_q + 2'(wr_en) - 2'(rd_pop);
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Head slot and the one behind it (used for gapless tile switchover).
    always_comb begin
        cur_tile  = slot_q[rd_ptr_q].tile;
        cur_meta  = slot_q[rd_ptr_q].meta;
        nxt_tile  = slot_q[~rd_ptr_q].tile;
        nxt_meta  = slot_q[~rd_ptr_q].meta;
        occupancy = occ_q;
    end

endmodule

// File: rtl/uds_out_packer.sv
// Output packer: captures result tiles into a 2-slot buffer and streams
// them as 256-bit row beats (LSB row first) over valid/ready.
// Optional stall/drop counters are built when UDS_OUT_PACKER_STATS_EN is defined.
module uds_out_packer
    import uds_pkg::*;
#(
    parameter int  A    = 64,
    localparam int IN_W = calc_in_w(A)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    input  logic [3:0]        in_beats,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ID_W-1:0]   out_tile_id,
    output logic              overflow,
`ifdef UDS_OUT_PACKER_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [15:0]       drop_cnt,
`endif
    output logic              busy
);

    localparam int NUM_BEATS = calc_num_beats(A);
    localparam logic [BCNT_W-1:0] NUM_BEATS_L = BCNT_W'(NUM_BEATS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [BEAT_W-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]   out_tile_id_q, out_tile_id_d;
    logic [BCNT_W-1:0] beat_q, beat_d;
    logic              overflow_q, overflow_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;

    logic [IN_W-1:0]   cur_tile, nxt_tile;
    slot_meta_t        cur_meta, nxt_meta, wr_meta;
    logic [1:0]        occ;
    logic [BCNT_W-1:0] beats_req, beats_eff;
    logic              hs, pop, accept, drop;
    logic [BEAT_W-1:0] cur_row_next;

    // Handshake, capture/drop decision and beat-count clamping.
    always_comb begin
        hs        = out_valid_q & out_ready;
        pop       = hs & out_last_q;
        accept    = in_valid & ((occ != 2'd2) | pop);
        drop      = in_valid & ~accept;
        beats_req = BCNT_W'(in_beats);
        beats_eff = ((beats_req == '0) || (beats_req > NUM_BEATS_L)) ? NUM_BEATS_L : beats_req;
        wr_meta.beats = beats_eff;
        wr_meta.id    = next_id_q;
        cur_row_next  = BEAT_W'(cur_tile >> (BEAT_W * int'(beat_q + 8'd1)));
    end

    uds_tile_slot2 #(
        .IN_W(IN_W)
    ) u_slots (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .wr_tile   (in_data),
        .wr_meta   (wr_meta),
        .rd_pop    (pop),
        .cur_tile  (cur_tile),
        .cur_meta  (cur_meta),
        .nxt_tile  (nxt_tile),
        .nxt_meta  (nxt_meta),
        .occupancy (occ)
    );

    // Streaming FSM next-state: load beat 0, advance on handshake, switch tiles without a bubble.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_data_d    = out_data_q;
        out_tile_id_d = out_tile_id_q;
        beat_d        = beat_q;
        overflow_d    = overflow_q | drop;
        next_id_d     = next_id_q + ID_W'(accept);
        case (state_q)
            IDLE: begin
                if (occ != 2'd0) begin
                    state_d       = SEND;
                    out_valid_d   = 1'b1;
                    beat_d        = '0;
                    out_data_d    = cur_tile[BEAT_W-1:0];
                    out_last_d    = (cur_meta.beats == 8'd1);
                    out_tile_id_d = cur_meta.id;
                end
            end
            SEND: begin
                if (hs) begin
                    if (out_last_q) begin
                        if (occ == 2'd2) begin
                            beat_d        = '0;
                            out_data_d    = nxt_tile[BEAT_W-1:0];
                            out_last_d    = (nxt_meta.beats == 8'd1);
                            out_tile_id_d = nxt_meta.id;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end
                    end else begin
                        beat_d     = beat_q + 8'd1;
                        out_data_d = cur_row_next;
                        out_last_d = (cur_meta.beats == (beat_q + 8'd2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, registered outputs, sticky overflow and id counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            out_tile_id_q <= '0;
            beat_q        <= '0;
            overflow_q    <= 1'b0;
            next_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
            out_tile_id_q <= out_tile_id_d;
            beat_q        <= beat_d;
            overflow_q    <= overflow_d;
            next_id_q     <= next_id_d;
        end
    end

`ifdef UDS_OUT_PACKER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating stall and drop counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_tile_id = out_tile_id_q;
    assign overflow    = overflow_q;
    assign busy        = (occ != 2'd0);

endmodule

// File: tb/tb_uds_out_packer.sv
// Self-checking bench for uds_out_packer: a queue-based tile model predicts
// every output cycle; directed and randomized scenarios run in sequence.
module tb_uds_out_packer;

    localparam int A         = 64;
    localparam int BW        = 256;
    localparam int IN_W      = 2 * (A - 8) * 32;
    localparam int NUM_BEATS = IN_W / BW;
    localparam int OW        = 1 + 1 + 8 + BW;

    logic            clk;
    logic            rst_n;
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic [3:0]      in_beats;
    logic [BW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [7:0]      out_tile_id;
    logic            overflow;
    logic            busy;
`ifdef UDS_OUT_PACKER_STATS_EN
    logic [31:0]     stall_cnt;
    logic [15:0]     drop_cnt;
`endif

    uds_out_packer #(.A(A)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_beats    (in_beats),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_tile_id (out_tile_id),
        .overflow    (overflow),
`ifdef UDS_OUT_PACKER_STATS_EN
        .stall_cnt   (stall_cnt),
        .drop_cnt    (drop_cnt),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending tiles in arrival order, head is being streamed.
    typedef struct {
        logic [IN_W-1:0] data;
        int              beats;
        int              id;
    } tile_t;

    tile_t q[$];
    bit    vis;
    int    k;
    int    next_id;
    bit    ovf;
    int    drops;
    int    stalls;

    function automatic void model_reset();
        q.delete();
        vis = 0; k = 0; next_id = 0; ovf = 0; drops = 0; stalls = 0;
    endfunction

    function automatic int eff_beats(input int b);
        return (b == 0 || b > NUM_BEATS) ? NUM_BEATS : b;
    endfunction

    // One clock edge of the model using the inputs currently driven.
    function automatic void model_edge();
        int    n0;
        bit    hs, lhs;
        tile_t t;
        n0  = q.size();
        hs  = vis && out_ready;
        lhs = hs && (k == q[0].beats - 1);
        if (vis && !out_ready) stalls++;
        if (lhs) begin
            t = q.pop_front();
            if (q.size() > 0) k = 0;
            else vis = 0;
        end else if (hs) begin
            k++;
        end else if (!vis && n0 > 0) begin
            vis = 1;
            k = 0;
        end
        if (in_valid) begin
            if (n0 - (lhs ? 1 : 0) < 2) begin
                t.data  = in_data;
                t.beats = eff_beats(int'(in_beats));
                t.id    = next_id;
                q.push_back(t);
                next_id = (next_id + 1) % 256;
            end else begin
                ovf = 1;
                drops++;
            end
        end
    endfunction

    function automatic logic [OW-1:0] exp_pack();
        logic [BW-1:0] row;
        if (!vis) return '0;
        row = BW'(q[0].data >> (k * BW));
        return {1'b1, (k == q[0].beats - 1), 8'(q[0].id), row};
    endfunction

    function automatic logic [OW-1:0] obs_pack();
        if (out_valid !== 1'b1) return {out_valid, {(OW-1){1'b0}}};
        return {1'b1, out_last, out_tile_id, out_data};
    endfunction

    function automatic logic [IN_W-1:0] rand_tile();
        logic [IN_W-1:0] t;
        t = '0;
        for (int i = 0; i < IN_W / 32; i++) t = (t << 32) | IN_W'($urandom);
        return t;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_beats = 4'd0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_beats = 4'd0; out_ready = 1'b0; in_data = '0;
        #3;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
        if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got=%b exp=0", out_last); end
        if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", out_data); end
        if (out_tile_id !== 8'd0) begin errors++; $display("[TB] FAIL reset_id got=%0d exp=0", out_tile_id); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        do_reset();
    endtask

    task automatic test_single_tile();
        logic [IN_W-1:0] t;
        int nb, last_at;
        do_reset();
        t = '0;
        for (int r = 0; r < NUM_BEATS; r++) t = t | (IN_W'({8{32'(r)}}) << (r * BW));
        nb = 0; last_at = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c == 0); in_beats = 4'd0; in_data = t;
            if (out_valid === 1'b1) begin
                if (out_last === 1'b1) last_at = nb;
                nb++;
            end
            cycle();
            checks += 2;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL single_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
            if (busy !== (q.size() != 0)) begin errors++; $display("[TB] FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, q.size() != 0); end
        end
        in_valid = 1'b0;
        checks += 2;
        if (nb != NUM_BEATS) begin errors++; $display("[TB] FAIL single_count got=%0d exp=%0d", nb, NUM_BEATS); end
        if (last_at != NUM_BEATS - 1) begin errors++; $display("[TB] FAIL single_last_pos got=%0d exp=%0d", last_at, NUM_BEATS - 1); end
    endtask

    task automatic test_backpressure();
        int nb, stalled;
        do_reset();
        nb = 0; stalled = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c == 0); in_beats = 4'd0; in_data = rand_tile();
            out_ready = !(vis && k == 3 && stalled < 5);
            if (!out_ready) stalled++;
            if (out_valid === 1'b1 && out_ready) nb++;
            cycle();
            checks++;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL bp_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
        end
        in_valid = 1'b0;
        checks += 2;
        if (nb != NUM_BEATS) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=%0d", nb, NUM_BEATS); end
        if (stalled != 5) begin errors++; $display("[TB] FAIL bp_stall_reached got=%0d exp=5", stalled); end
    endtask

    task automatic test_back_to_back();
        int nvalid, first_v, last_v;
        logic [5:0] lastmask;
        do_reset();
        nvalid = 0; first_v = -1; last_v = -1; lastmask = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 2); in_beats = (c == 0) ? 4'd4 : 4'd2; in_data = rand_tile();
            cycle();
            checks++;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL b2b_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                if (out_last === 1'b1 && nvalid < 6) lastmask[nvalid] = 1'b1;
                nvalid++;
            end
        end
        in_valid = 1'b0;
        checks += 3;
        if (nvalid != 6) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=6", nvalid); end
        if (last_v - first_v != 5) begin errors++; $display("[TB] FAIL b2b_gap span=%0d exp=5", last_v - first_v); end
        if (lastmask !== 6'b101000) begin errors++; $display("[TB] FAIL b2b_lastpos got=%b exp=101000", lastmask); end
    endtask

    task automatic test_overflow();
        int ids[$];
        do_reset();
        for (int c = 0; c < 40; c++) begin
            in_valid = (c < 3); in_beats = 4'd0; in_data = rand_tile();
            out_ready = (c >= 6);
            if (out_valid === 1'b1 && out_ready && out_last === 1'b1) ids.push_back(int'(out_tile_id));
            cycle();
            checks++;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL ovf_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
        end
        in_valid = 1'b0;
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        if (ids.size() != 2) begin errors++; $display("[TB] FAIL ovf_tiles got=%0d exp=2", ids.size()); end
        else if (ids[0] != 0 || ids[1] != 1) begin errors++; $display("[TB] FAIL ovf_ids got=%0d,%0d exp=0,1", ids[0], ids[1]); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_busy got=%b exp=0", busy); end
`ifdef UDS_OUT_PACKER_STATS_EN
        checks += 2;
        if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); end
        if (stall_cnt !== 32'(stalls)) begin errors++; $display("[TB] FAIL ovf_stall_cnt got=%0d exp=%0d", stall_cnt, stalls); end
`endif
    endtask

    task automatic test_simultaneous();
        int ids[$];
        bit sent;
        do_reset();
        sent = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 2);
            if (c >= 2 && !sent && vis && k == q[0].beats - 1 && q.size() == 2) begin
                in_valid = 1'b1;
                sent = 1;
            end
            in_beats = 4'd2; in_data = rand_tile();
            if (out_valid === 1'b1 && out_last === 1'b1) ids.push_back(int'(out_tile_id));
            cycle();
            checks += 2;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL simul_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
            if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL simul_overflow cyc=%0d got=%b exp=0", c, overflow); end
        end
        in_valid = 1'b0;
        checks += 2;
        if (!sent) begin errors++; $display("[TB] FAIL simul_trigger got=0 exp=1"); end
        if (ids.size() != 3) begin errors++; $display("[TB] FAIL simul_tiles got=%0d exp=3", ids.size()); end
        else if (ids[0] != 0 || ids[1] != 1 || ids[2] != 2) begin errors++; $display("[TB] FAIL simul_ids got=%0d,%0d,%0d exp=0,1,2", ids[0], ids[1], ids[2]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_beats  = 4'($urandom_range(0, 15));
            in_data   = rand_tile();
            out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle();
            checks += 3;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL rand_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
            if (busy !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, q.size() != 0); end
            if (overflow !== ovf) begin errors++; $display("[TB] FAIL rand_overflow cyc=%0d got=%b exp=%b", c, overflow, ovf); end
        end
        in_valid = 1'b0;
`ifdef UDS_OUT_PACKER_STATS_EN
        checks += 2;
        if (drop_cnt !== 16'(drops)) begin errors++; $display("[TB] FAIL rand_drop_cnt got=%0d exp=%0d", drop_cnt, drops); end
        if (stall_cnt !== 32'(stalls)) begin errors++; $display("[TB] FAIL rand_stall_cnt got=%0d exp=%0d", stall_cnt, stalls); end
`endif
    endtask

    task automatic test_reset_mid();
        bit reached;
        do_reset();
        reached = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !reached; c++) begin
            in_valid = (c == 0); in_beats = 4'd0; in_data = rand_tile();
            cycle();
            checks++;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL rmid_beat cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
            if (vis && k == 7) reached = 1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks += 6;
        if (!reached) begin errors++; $display("[TB] FAIL rmid_reach got=0 exp=1"); end
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid_last got=%b%b exp=00", out_valid, out_last); end
        if (out_data !== '0) begin errors++; $display("[TB] FAIL rmid_data got=%h exp=0", out_data); end
        if (out_tile_id !== 8'd0) begin errors++; $display("[TB] FAIL rmid_id got=%0d exp=0", out_tile_id); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got=%b exp=0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rmid_overflow got=%b exp=0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 1); in_beats = 4'd0; in_data = rand_tile();
            cycle();
            checks += 2;
            if (obs_pack() !== exp_pack()) begin errors++; $display("[TB] FAIL rmid_after cyc=%0d got=%h exp=%h", c, obs_pack(), exp_pack()); end
            if (busy !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rmid_after_busy cyc=%0d got=%b exp=%b", c, busy, q.size() != 0); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_tile();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uds_out_packer.md
Name: uds_out_packer

Overview:
- Downstream stage of the up/down-sample engine: captures each wide result tile (pulsed valid, no backpressure upstream) and streams it out as 256-bit row beats with a valid/ready handshake toward the writeback/DMA path.
- Two-tile ping-pong buffer absorbs downstream stalls; tiles arriving while both slots are full are dropped and flagged.

Parameters:
- A, 64, items per input tile (8x8); legal values: multiple of 4, greater than 8.
- BEAT_W, 256, output beat width: one row of 8 items x 32 bit.
- IN_W, 2*(A-8)*32, input tile width (derived localparam, 3584 at default).
- NUM_BEATS, IN_W/BEAT_W, beats per full tile (derived localparam, 14 at default).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  IN_W  result tile from the sample engine.
- in_valid  in  1  one-cycle tile strobe; no ready is returned.
- in_beats  in  4  beats to emit for this tile, 1..NUM_BEATS; 0 means NUM_BEATS; values above NUM_BEATS are clamped to NUM_BEATS.
- out_data  out  BEAT_W  current beat.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_last  out  1  final beat of the tile; qualified by out_valid.
- out_tile_id  out  8  tile sequence number, wraps 255 to 0.
- overflow  out  1  sticky; set when a tile is dropped.
- busy  out  1  at least one buffer slot is occupied.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_last=0, out_data=0, out_tile_id=0, overflow=0, busy=0; both slots empty; read/write pointers=0; beat counter=0; FSM=IDLE.
- Storage: two slots, each holding {tile, beat count, id}. Write pointer and read pointer are 1 bit each; occupancy counter is 0..2.
- Capture: in_valid=1 with occupancy<2 writes the slot at the write pointer and assigns the next id. in_valid=1 with occupancy==2 drops the tile, sets overflow, and does not advance the id.
- Simultaneous free and capture: if the last beat handshakes in the same cycle as in_valid while occupancy==2, the tile is accepted; occupancy stays 2 and there is no overflow.
- FSM states are IDLE and SEND.
  - IDLE to SEND when occupancy>0. Outputs are registered, so a tile captured at edge t gives out_valid=1 from t+1, with beat 0.
  - SEND: out_data = slot[rd][k*BEAT_W +: BEAT_W], where k is the beat counter starting at 0 (the LSB row goes first).
  - A beat advances only on out_valid & out_ready. out_data, out_last, and out_tile_id are held stable while out_valid & !out_ready.
  - out_last=1 when k == beats-1.
  - After a last-beat handshake: free the slot and toggle rd. If another slot is occupied, stay in SEND and present its beat 0 in the next cycle, with no bubble. Otherwise go to IDLE and drop out_valid.
- Throughput: one beat per cycle while out_ready=1. A full tile takes NUM_BEATS cycles.
- A 1-beat tile asserts out_last on its only beat.
- overflow clears only on reset.
- busy = (occupancy != 0).

Optional Feature:
- Macro: UDS_OUT_PACKER_STATS_EN.
- When defined, two extra outputs are present:
  - stall_cnt [31:0]: increments each cycle with out_valid & !out_ready; saturates at all-ones.
  - drop_cnt [15:0]: increments on each dropped tile; saturates.
  - Both reset to 0.
- When undefined, these ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Shared package uds_pkg holds:
  - ROW_ITEMS=8 and ITEM_W=32.
  - BEAT_W.
  - Function to derive NUM_BEATS(A).
  - Typedef for the slot record {tile, beats, id}.
- Natural sub-module: uds_tile_slot2, the 2-entry tile store with pointers and occupancy. The FSM and beat mux stay in the top module.

Test Plan:
- Single tile, A=64, in_beats=0, out_ready=1, row k filled with 32'hk repeated: 14 beats on consecutive cycles starting at t+1; out_last on beat 13; out_tile_id=0; busy falls after the last beat.
- Backpressure: out_ready=0 for 5 cycles mid-tile at beat 3, then 1: beat 3 is held unchanged with out_valid=1 throughout; remaining beats are correct; no beat is lost or duplicated.
- Back-to-back tiles with in_beats=4, then 2, out_ready=1: 6 beats with no idle cycle; out_last on beats 3 and 5; ids 0 then 1.
- Overflow: out_ready=0 and three tiles strobed: first two buffered, third dropped; overflow=1; after releasing out_ready, only ids 0 and 1 appear. With the macro defined, drop_cnt=1 and stall_cnt equals the number of stalled cycles.
- Simultaneous free and capture: occupancy 2 and in_valid coincides with the last-beat handshake: tile accepted, overflow stays 0, id 2 is emitted next.
- Reset mid-transfer: rst_n low at beat 7: outputs go to 0 immediately; after release, busy=0 and the next tile emits beat 0 with id 0.
